truth_table_scanner: RTL and testbench

Sequential sweep-and-capture stage for 4-input combinational logic blocks: on `start` it drives every input combination 0..2^N_IN−1 in ascending order onto `vec`, samples the block's single output `f` after a programmable settle time, and assembles the full truth table plus a minterm count. It sits on both sides of the combinational function under test. It feeds the function inputs `{a,b,c,d}`, with `vec[N_IN-1]` = a as the MSB, and it consumes the function output.

---
 rtl/truth_table_scanner.sv | 128 ++++++++++++
 tb/tb_truth_table_scanner.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//
// Sweeps every input combination 0..2^N_IN-1 in ascending order onto `vec`,
// waits SETTLE cycles for the combinational function under test to settle,
// samples its output `f` into `table_out[vec]`, and counts the 1 entries.
//
// Handshake: `start` is a request sampled only while IDLE; a scan cannot be
// queued or restarted while `busy` is high. Completion is reported by a
// one-cycle `done` pulse, and `table_out`/`ones_cnt` are valid in that cycle
// and hold until the next accepted `start` or `rst`.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (wins over start)
//   start      in   scan request, sampled only in IDLE
//   f          in   output of the function under test (combinational of vec)
//   vec        out  registered vector driven to the function, vec[N_IN-1] = MSB
//   busy       out  high while a scan is in progress
//   done       out  one-cycle pulse when the table is complete
//   table_out  out  table_out[i] = f(vec = i)
//   ones_cnt   out  number of 1 entries in table_out, 0..2^N_IN
//   state_dbg  out  current FSM state (0 = IDLE, 1 = SCAN)
module truth_table_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   f,
    output logic [N_IN-1:0]        vec,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          ones_cnt,
    output logic                   state_dbg
);

    localparam int TBL_W  = 1 << N_IN;
    localparam int ONES_W = N_IN + 1;
    // The counter only has to reach SETTLE-1; keep at least one bit.
    localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [N_IN-1:0]  VEC_LAST   = '1;
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SETTLE - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [TBL_W-1:0]   table_q, table_d;
    logic [ONES_W-1:0]  ones_q, ones_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;          // done is a single-cycle pulse
        table_d = table_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    busy_d  = 1'b1;
                    vec_d   = '0;
                    table_d = '0;
                    ones_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (cnt_q == CNT_SAMPLE) begin
                    table_d[vec_q] = f;
                    ones_d         = ones_q + ONES_W'(f);
                    cnt_d          = '0;
                    vec_d          = vec_q + N_IN'(1);  // wraps to 0 after the last vector
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign vec       = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign ones_cnt  = ones_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: default instance (N_IN=4, SETTLE=1) driven by
// a table-defined function, plus a SETTLE=3 instance and an N_IN=2 instance.
module tb_truth_table_scanner;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- default instance ----------------
    logic        start = 1'b0;
    logic [15:0] f_tbl = '0;
    logic        f;
    logic [3:0]  vec;
    logic        busy, done, state_dbg;
    logic [15:0] table_out;
    logic [4:0]  ones_cnt;

    assign f = f_tbl[vec];

    truth_table_scanner #(.N_IN(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .f(f), .vec(vec), .busy(busy),
        .done(done), .table_out(table_out), .ones_cnt(ones_cnt), .state_dbg(state_dbg)
    );

    // ---------------- SETTLE=3 instance, f = vec[0] ----------------
    logic        start3 = 1'b0;
    logic        f3;
    logic [3:0]  vec3;
    logic        busy3, done3, state3;
    logic [15:0] table3;
    logic [4:0]  ones3;

    assign f3 = vec3[0];

    truth_table_scanner #(.N_IN(4), .SETTLE(3)) dut_s3 (
        .clk(clk), .rst(rst), .start(start3), .f(f3), .vec(vec3), .busy(busy3),
        .done(done3), .table_out(table3), .ones_cnt(ones3), .state_dbg(state3)
    );

    // ---------------- N_IN=2 instance, f = vec[1] & vec[0] ----------------
    logic        start2 = 1'b0;
    logic        f2;
    logic [1:0]  vec2;
    logic        busy2, done2, state2;
    logic [3:0]  table2;
    logic [2:0]  ones2;

    assign f2 = vec2[1] & vec2[0];

    truth_table_scanner #(.N_IN(2), .SETTLE(1)) dut_n2 (
        .clk(clk), .rst(rst), .start(start2), .f(f2), .vec(vec2), .busy(busy2),
        .done(done2), .table_out(table2), .ones_cnt(ones2), .state_dbg(state2)
    );

    // ---------------- reference model ----------------
    // Boolean function from the datasheet example, evaluated on vector i = {a,b,c,d}.
    function automatic logic spec_f(input int i);
        logic a, b, c, d;
        a = i[3]; b = i[2]; c = i[1]; d = i[0];
        return (~c & d) | (a & ~c) | (a & ~b) | (~a & b & d);
    endfunction

    function automatic int popcount16(input logic [15:0] t);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(t[i]);
        return n;
    endfunction

    // Observations of one default-instance scan, index c = cycle after edge T0+c.
    logic [3:0]  exp_q[$];
    logic [3:0]  obs_vec[$];
    logic        obs_busy[$];
    logic        obs_done[$];
    logic [15:0] obs_tbl[$];
    logic [4:0]  obs_ones[$];

    // Starts one scan of the default instance with function table `tbl` and
    // records outputs for cycles T0..T0+17. With rand_start, start toggles
    // randomly while the scan is running (it must be ignored).
    task automatic drive_scan(input logic [15:0] tbl, input bit rand_start);
        f_tbl = tbl;
        obs_vec.delete(); obs_busy.delete(); obs_done.delete();
        obs_tbl.delete(); obs_ones.delete();
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= 17; c++) begin
            obs_vec.push_back(vec);
            obs_busy.push_back(busy);
            obs_done.push_back(done);
            obs_tbl.push_back(table_out);
            obs_ones.push_back(ones_cnt);
            start = (rand_start && c <= 14) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (vec !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || table_out !== 16'h0 ||
            ones_cnt !== 5'd0 || state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: vec=%0d busy=%b done=%b table=%h ones=%0d state=%b, want all 0",
                     vec, busy, done, table_out, ones_cnt, state_dbg);
        end
        // rst and start on the same edge: rst wins.
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL rst_over_start: busy=%b state=%b, want 0 0", busy, state_dbg);
        end
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_spec_function;
        logic [15:0] tbl;
        int bad = 0;
        for (int i = 0; i < 16; i++) tbl[i] = spec_f(i);
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(4'(k));
        drive_scan(tbl, 1'b0);
        for (int c = 0; c < 16; c++) begin
            logic [3:0] ev;
            ev = exp_q.pop_front();
            if (obs_vec[c] !== ev || obs_busy[c] !== 1'b1 || obs_done[c] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL spec_sweep: %0d cycles with wrong vec/busy/done, want 0", bad);
        end
        checks++;
        if (obs_done[16] !== 1'b1 || obs_tbl[16] !== 16'h3FA2 || obs_ones[16] !== 5'd9) begin
            errors++;
            $display("FAIL spec_result: done=%b table=%h ones=%0d, want 1 3fa2 9",
                     obs_done[16], obs_tbl[16], obs_ones[16]);
        end
        checks++;
        if (obs_done[17] !== 1'b0 || obs_busy[17] !== 1'b0 || obs_vec[17] !== 4'd0 ||
            obs_tbl[17] !== 16'h3FA2) begin
            errors++;
            $display("FAIL spec_after: done=%b busy=%b vec=%0d table=%h, want 0 0 0 3fa2",
                     obs_done[17], obs_busy[17], obs_vec[17], obs_tbl[17]);
        end
    endtask

    task automatic test_const_zero_one;
        drive_scan(16'h0000, 1'b0);
        checks++;
        if (obs_done[16] !== 1'b1 || obs_tbl[16] !== 16'h0000 || obs_ones[16] !== 5'd0) begin
            errors++;
            $display("FAIL const_zero: done=%b table=%h ones=%0d, want 1 0000 0",
                     obs_done[16], obs_tbl[16], obs_ones[16]);
        end
        drive_scan(16'hFFFF, 1'b0);
        checks++;
        if (obs_done[16] !== 1'b1 || obs_tbl[16] !== 16'hFFFF || obs_ones[16] !== 5'b10000) begin
            errors++;
            $display("FAIL const_one: done=%b table=%h ones=%0d, want 1 ffff 16",
                     obs_done[16], obs_tbl[16], obs_ones[16]);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            logic [15:0] tbl;
            int bad = 0;
            int exp_ones;
            tbl      = 16'($urandom);
            exp_ones = popcount16(tbl);
            exp_q.delete();
            for (int k = 0; k < 16; k++) exp_q.push_back(4'(k));
            drive_scan(tbl, 1'b1);
            for (int c = 0; c < 16; c++) begin
                logic [3:0] ev;
                ev = exp_q.pop_front();
                if (obs_vec[c] !== ev || obs_busy[c] !== 1'b1 || obs_done[c] !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_sweep[%0d]: %0d cycles with wrong vec/busy/done, want 0", r, bad);
            end
            checks++;
            if (obs_done[16] !== 1'b1 || obs_tbl[16] !== tbl || int'(obs_ones[16]) != exp_ones ||
                obs_done[17] !== 1'b0) begin
                errors++;
                $display("FAIL random_result[%0d]: done=%b table=%h ones=%0d next_done=%b, want 1 %h %0d 0",
                         r, obs_done[16], obs_tbl[16], obs_ones[16], obs_done[17], tbl, exp_ones);
            end
        end
    endtask

    task automatic test_start_held;
        int bad_done = 0;
        int bad_busy = 0;
        int bad_clr  = 0;
        int bad_res  = 0;
        bit seen     = 1'b0;
        f_tbl = 16'hFFFF;
        start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done !== ((c % 17) == 16)) bad_done++;
            if (busy !== ((c % 17) != 16)) bad_busy++;
            if ((c % 17) == 0 && (table_out !== 16'h0 || ones_cnt !== 5'd0)) bad_clr++;
            if ((c % 17) == 16 && (table_out !== 16'hFFFF || ones_cnt !== 5'd16)) bad_res++;
        end
        checks++;
        if (bad_done != 0 || bad_busy != 0) begin
            errors++;
            $display("FAIL start_held_period: bad done cycles=%0d bad busy cycles=%0d, want 0 0",
                     bad_done, bad_busy);
        end
        checks++;
        if (bad_clr != 0 || bad_res != 0) begin
            errors++;
            $display("FAIL start_held_table: bad clears=%0d bad results=%0d, want 0 0", bad_clr, bad_res);
        end
        start = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL start_held_drain: done=0 within 20 cycles, want 1");
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan;
        bit saw_done = 1'b0;
        f_tbl = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (vec !== 4'd7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: vec=%0d busy=%b, want 7 1", vec, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (vec !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || table_out !== 16'h0 ||
            ones_cnt !== 5'd0 || state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: vec=%0d busy=%b done=%b table=%h ones=%0d state=%b, want all 0",
                     vec, busy, done, table_out, ones_cnt, state_dbg);
        end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: done/busy seen after abort=1, want 0");
        end
    endtask

    task automatic test_settle3;
        logic [15:0] exp_tbl;
        int bad = 0;
        for (int i = 0; i < 16; i++) exp_tbl[i] = (i % 2 == 1);
        exp_q.delete();
        for (int c = 0; c < 48; c++) exp_q.push_back(4'(c / 3));
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int c = 0; c < 48; c++) begin
            logic [3:0] ev;
            ev = exp_q.pop_front();
            if (vec3 !== ev || busy3 !== 1'b1 || done3 !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL settle3_sweep: %0d cycles with wrong vec/busy/done, want 0", bad);
        end
        checks++;
        if (done3 !== 1'b1 || table3 !== exp_tbl || ones3 !== 5'd8 || vec3 !== 4'd0 || state3 !== 1'b0) begin
            errors++;
            $display("FAIL settle3_result: done=%b table=%h ones=%0d vec=%0d state=%b, want 1 %h 8 0 0",
                     done3, table3, ones3, vec3, state3, exp_tbl);
        end
        @(negedge clk);
        checks++;
        if (done3 !== 1'b0) begin
            errors++;
            $display("FAIL settle3_done_clear: done=%b, want 0", done3);
        end
    endtask

    task automatic test_n_in2;
        logic [3:0] exp_tbl;
        int bad = 0;
        for (int i = 0; i < 4; i++) exp_tbl[i] = (i == 3);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (int'(vec2) != c || busy2 !== 1'b1 || done2 !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL n2_sweep: %0d cycles with wrong vec/busy/done, want 0", bad);
        end
        checks++;
        if (done2 !== 1'b1 || table2 !== exp_tbl || ones2 !== 3'd1 || state2 !== 1'b0) begin
            errors++;
            $display("FAIL n2_result: done=%b table=%b ones=%0d state=%b, want 1 %b 1 0",
                     done2, table2, ones2, state2, exp_tbl);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_spec_function();
        test_const_zero_one();
        test_random();
        test_start_held();
        test_reset_mid_scan();
        test_settle3();
        test_n_in2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
